trng_mc_warbler: RTL and testbench
==================================

Name: trng_mc_warbler

Overview:
- Parametrised successor of the single-channel warbler TRNG top.
- NUM_CH independent nonlinear generators, each with NLFSR A, NLFSR B, a 5-bit tweak shift register and NLFSR C.
- Seeded through a one-cycle seed strobe, warmed up for INIT_ROUNDS cycles, then their output bits are packed into OUT_W-bit words.
- Words are delivered over a valid/ready handshake with back-pressure; sits between the entropy/seed source and the crypto/consumer interconnect.

Parameters:
NUM_CH, 2, number of parallel generator channels (1..8)
OUT_W, 8, output word width; must be a multiple of NUM_CH
INIT_ROUNDS, 64, warm-up steps after each seed load (1..1023)
RCT_LIMIT, 16, repetition-count threshold for the optional health test (2..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
seed_valid  input  1  one-cycle strobe; loads seed into all channels, accepted in any state
seed  input  32  seed word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid && out_ready
out_data  output  OUT_W  packed random word
busy  output  1  high in INIT state
health_fail  output  1  sticky health-test failure (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE; all A/B/C/s/pack/counter registers 0; out_valid=0, out_data=0, busy=0, health_fail=0. Reset mid-operation discards everything; a new seed is required.
- Per-channel generator c, one step per enabled edge. Shift right, new bit into MSB:
  - A 13 bits: a_fb = A[0]^A[5]^(A[8]&A[11])^fz
  - B 11 bits: b_fb = B[0]^B[3]^(B[6]&B[9])^fz
  - s 5 bits: s <= {A[0]^B[0], s[4:1]}
  - C 8 bits: c_fb = C[0]^C[4]^(C[2]&C[6])^(^s)
  - z = C[0]^A[3]^B[2]
  - fz = z in INIT, fz = 0 in RUN.
- Seed load (edge where seed_valid=1, any state):
  - A<=seed[12:0], then A[0] forced to 1 if A would be all-zero.
  - B<=seed[23:13]; C<=seed[31:24]^c (channel index in low bits); s<=0.
  - pack count<=0, round<=0, out_valid<=0, health counters cleared, state<=INIT.
  - seed_valid overrides every other event on that edge, including a simultaneous handshake; the pending word is dropped.
- States:
  - IDLE: no steps; ignores out_ready.
  - INIT: busy=1; one step per edge; after INIT_ROUNDS steps, state<=RUN.
  - RUN: step enabled unless (pack count==K-1 && out_valid && !out_ready), where K=OUT_W/NUM_CH. Each RUN step writes z of channel c into pack[k*NUM_CH+c], where k is the pack count.
  - At step k=K-1: out_data<=completed word, out_valid<=1, k<=0.
- Handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid falls on the accepting edge unless a new word completes on that same edge; in that case it stays 1 with the new data.
- Latency: seed edge E0; INIT steps E1..E_INIT_ROUNDS; out_valid rises after edge E_(INIT_ROUNDS+K). Defaults give 68 edges.
- Sustained throughput with out_ready held at 1: one word per K cycles.

Optional Feature:
- Macro TRNG_HEALTH_TEST_EN.
- Defined:
  - Repetition-count test on channel 0's z during RUN steps.
  - When RCT_LIMIT consecutive identical bits are seen, health_fail<=1 (sticky) and out_valid is forced to 0; no further words are produced.
  - Only a seed load or reset clears health_fail.
  - Counter saturates at RCT_LIMIT and restarts at 1 on a bit change.
- Undefined: health_fail tied to 0; no counter logic.

Test Plan:
- Reset then seed=32'hDEADBEEF, out_ready=1 -> busy high for 64 cycles; out_valid first high exactly 68 edges after the seed edge; out_data matches the bit-accurate reference model; then one word every 4 cycles.
- seed=0 -> A loads as 13'h0001; generator produces non-constant output matching the model, with no lock-up over 1000 words.
- out_ready=0 for 20 cycles after the first word -> out_valid stays 1 and out_data holds; out_ready=1 -> word accepted, and the next word equals the model's second word (no bits lost or skipped).
- seed_valid asserted mid-RUN while out_valid=1 -> out_valid 0 the next cycle; busy=1; sequence restarts identical to a fresh seed of the same value.
- rst pulled low during INIT, then released, no seed -> outputs stay at reset values, state IDLE, no out_valid indefinitely.
- TRNG_HEALTH_TEST_EN, RCT_LIMIT=4, channel 0 z forced constant via a model-chosen seed or bench force -> health_fail=1 after 4 identical bits; out_valid stays 0; a reseed clears health_fail.

Source files
------------

// File: rtl/trng_mc_warbler.sv
// Multi-channel warbler TRNG: NUM_CH nonlinear generators packed into OUT_W-bit words over valid/ready.
// Optional repetition-count health test on channel 0 enabled by defining TRNG_HEALTH_TEST_EN.
module trng_mc_warbler_ch #(
    parameter int CH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        init,
    input  logic [31:0] seed,
    output logic        z
);
    logic [12:0] a;
    logic [10:0] b;
    logic [7:0]  c;
    logic [4:0]  s;
    logic        fz;

    assign z  = c[0] ^ a[3] ^ b[2];
    assign fz = init & z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a <= '0;
            b <= '0;
            c <= '0;
            s <= '0;
        end else if (load) begin
            // an all-zero A would lock the register up
            a <= (seed[12:0] == 13'd0) ? 13'h0001 : seed[12:0];
            b <= seed[23:13];
            c <= seed[31:24] ^ 8'(CH);
            s <= '0;
        end else if (step) begin
            a <= {a[0] ^ a[5] ^ (a[8] & a[11]) ^ fz, a[12:1]};
            b <= {b[0] ^ b[3] ^ (b[6] & b[9]) ^ fz, b[10:1]};
            s <= {a[0] ^ b[0], s[4:1]};
            c <= {c[0] ^ c[4] ^ (c[2] & c[6]) ^ (^s), c[7:1]};
        end
    end
endmodule

module trng_mc_warbler #(
    parameter int NUM_CH      = 2,
    parameter int OUT_W       = 8,
    parameter int INIT_ROUNDS = 64,
    parameter int RCT_LIMIT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             health_fail
);
    localparam int K  = OUT_W / NUM_CH;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    if (OUT_W % NUM_CH != 0 || NUM_CH < 1 || NUM_CH > 8 || RCT_LIMIT < 2 || RCT_LIMIT > 255 ||
        INIT_ROUNDS < 1 || INIT_ROUNDS > 1023) begin : g_bad_param
        $error("trng_mc_warbler: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [9:0]        round;
    logic [OUT_W-1:0]  pack, word_next;
    logic [NUM_CH-1:0] z;
    logic              last_slot, stall, step, run_step, trip;

    assign last_slot = (k == KW'(K - 1));
    assign stall     = last_slot && out_valid && !out_ready;
    assign run_step  = (state == RUN) && !stall && !health_fail;
    assign step      = (state == INIT) || run_step;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        trng_mc_warbler_ch #(.CH(g)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .load (seed_valid),
            .step (step),
            .init (state == INIT),
            .seed (seed),
            .z    (z[g])
        );
    end

    // slot k of the word collects one bit from every channel
    for (genvar kk = 0; kk < K; kk++) begin : g_slot
        for (genvar g = 0; g < NUM_CH; g++) begin : g_bit
            assign word_next[kk*NUM_CH+g] = (k == KW'(kk)) ? z[g] : pack[kk*NUM_CH+g];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            round     <= '0;
            pack      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (seed_valid) begin
            state     <= INIT;
            k         <= '0;
            round     <= '0;
            pack      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    round <= round + 10'd1;
                    if (round == 10'(INIT_ROUNDS - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (run_step) begin
                        pack <= word_next;
                        if (last_slot) begin
                            out_data  <= word_next;
                            out_valid <= 1'b1;
                            k         <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    if (trip)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef TRNG_HEALTH_TEST_EN
    localparam int RW = $clog2(RCT_LIMIT + 1);

    logic [RW-1:0] rct_cnt, rct_nxt;
    logic          rct_bit;

    always_comb begin
        rct_nxt = RW'(1);
        if (rct_cnt != '0 && z[0] == rct_bit)
            rct_nxt = (rct_cnt == RW'(RCT_LIMIT)) ? rct_cnt : rct_cnt + 1'b1;
    end

    assign trip = run_step && (rct_nxt == RW'(RCT_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rct_cnt     <= '0;
            rct_bit     <= 1'b0;
            health_fail <= 1'b0;
        end else if (seed_valid) begin
            rct_cnt     <= '0;
            rct_bit     <= 1'b0;
            health_fail <= 1'b0;
        end else if (run_step) begin
            rct_cnt <= rct_nxt;
            rct_bit <= z[0];
            if (trip)
                health_fail <= 1'b1;
        end
    end
`else
    assign trip        = 1'b0;
    assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_trng_mc_warbler.sv
// Bench for trng_mc_warbler: directed sequence with random seeds/back-pressure against a bit-list reference model.
module tb_trng_mc_warbler;
    localparam int NUM_CH      = 2;
    localparam int OUT_W       = 8;
    localparam int INIT_ROUNDS = 64;
    localparam int K           = OUT_W / NUM_CH;
`ifdef TRNG_HEALTH_TEST_EN
    localparam int RCT = 4;
`else
    localparam int RCT = 16;
`endif

    typedef logic [OUT_W-1:0] word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             seed_valid = 1'b0;
    logic [31:0]      seed = '0;
    logic             out_ready = 1'b0;
    logic             out_valid, busy, health_fail;
    logic [OUT_W-1:0] out_data;

    int checks = 0;
    int errors = 0;

    word_t exp_q[$];
    bit    z0_q[$];
    bit    ma[NUM_CH][13];
    bit    mb[NUM_CH][11];
    bit    mc[NUM_CH][8];
    bit    ms[NUM_CH][5];

    trng_mc_warbler #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .INIT_ROUNDS(INIT_ROUNDS), .RCT_LIMIT(RCT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_valid  (seed_valid),
        .seed        (seed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each register kept as a plain bit list, index 0 is the bit shifted out.
    function automatic void m_load(input logic [31:0] sd);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit any = 0;
            for (int i = 0; i < 13; i++) begin ma[ch][i] = sd[i]; any |= sd[i]; end
            if (!any) ma[ch][0] = 1;
            for (int i = 0; i < 11; i++) mb[ch][i] = sd[13+i];
            for (int i = 0; i < 8; i++)  mc[ch][i] = sd[24+i] ^ bit'((ch >> i) & 1);
            for (int i = 0; i < 5; i++)  ms[ch][i] = 0;
        end
    endfunction

    function automatic bit m_step(input int ch, input bit init);
        bit zz  = mc[ch][0] ^ ma[ch][3] ^ mb[ch][2];
        bit fz  = init ? zz : 1'b0;
        bit afb = ma[ch][0] ^ ma[ch][5] ^ (ma[ch][8] & ma[ch][11]) ^ fz;
        bit bfb = mb[ch][0] ^ mb[ch][3] ^ (mb[ch][6] & mb[ch][9]) ^ fz;
        bit sn  = ma[ch][0] ^ mb[ch][0];
        bit sp  = 0;
        bit cfb;
        for (int i = 0; i < 5; i++) sp ^= ms[ch][i];
        cfb = mc[ch][0] ^ mc[ch][4] ^ (mc[ch][2] & mc[ch][6]) ^ sp;
        for (int i = 0; i < 12; i++) ma[ch][i] = ma[ch][i+1];
        ma[ch][12] = afb;
        for (int i = 0; i < 10; i++) mb[ch][i] = mb[ch][i+1];
        mb[ch][10] = bfb;
        for (int i = 0; i < 4; i++) ms[ch][i] = ms[ch][i+1];
        ms[ch][4] = sn;
        for (int i = 0; i < 7; i++) mc[ch][i] = mc[ch][i+1];
        mc[ch][7] = cfb;
        return zz;
    endfunction

    function automatic void model(input logic [31:0] sd, input int nw);
        exp_q.delete();
        z0_q.delete();
        m_load(sd);
        repeat (INIT_ROUNDS)
            for (int ch = 0; ch < NUM_CH; ch++) void'(m_step(ch, 1'b1));
        for (int w = 0; w < nw; w++) begin
            word_t wd = '0;
            for (int kk = 0; kk < K; kk++)
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    bit zz = m_step(ch, 1'b0);
                    wd[kk*NUM_CH+ch] = zz;
                    if (ch == 0) z0_q.push_back(zz);
                end
            exp_q.push_back(wd);
        end
    endfunction

    task automatic do_seed(input logic [31:0] sd);
        seed       = sd;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    // Consume nw words with optional random back-pressure, checking order and hold stability.
    task automatic collect(input int nw, input bit rnd, input string tag, output bit varied);
        int    idx = 0;
        int    cyc = 0;
        bit    held = 0;
        word_t held_d = '0;
        word_t first = '0;
        varied = 0;
        while (idx < nw && cyc < nw * 20 + 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) chk({tag, " hold"}, {out_valid, out_data}, {1'b1, held_d});
            if (out_valid && out_ready) begin
                chk(tag, out_data, exp_q[idx]);
                if (idx == 0) first = out_data;
                else if (out_data != first) varied = 1;
                idx++;
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
            tick();
            cyc++;
        end
        chk({tag, " count"}, idx, nw);
    endtask

    initial begin
        int          n, busy_cnt, bad;
        bit          varied;
        logic [31:0] sd;

        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset busy", busy, 0);
        chk("reset health_fail", health_fail, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

`ifdef TRNG_HEALTH_TEST_EN
        // find a seed whose channel-0 run stream repeats RCT times within 200 RUN steps
        sd = 32'hDEADBEEF;
        n  = 0;
        for (int att = 0; att < 20 && n == 0; att++) begin
            int run = 0;
            model(sd, 50);
            for (int i = 0; i < z0_q.size(); i++) begin
                run = (i == 0 || z0_q[i] != z0_q[i-1]) ? 1 : run + 1;
                if (run == RCT) begin n = i + 1; break; end
            end
            if (n == 0) sd = $urandom;
        end
        out_ready = 1'b1;
        do_seed(sd);
        busy_cnt = 0;
        while (!health_fail && busy_cnt < INIT_ROUNDS + 300) begin
            tick();
            busy_cnt++;
        end
        chk("health trip edge", busy_cnt, INIT_ROUNDS + n);
        chk("health out_valid", out_valid, 0);
        bad = 0;
        repeat (20) begin tick(); if (out_valid || !health_fail) bad++; end
        chk("health sticky no words", bad, 0);
        do_seed(sd);
        chk("health cleared by seed", health_fail, 0);
        chk("health reseed busy", busy, 1);
`else
        // fresh seed: latency, busy length, first word, then one word per K cycles
        model(32'hDEADBEEF, 12);
        out_ready = 1'b1;
        do_seed(32'hDEADBEEF);
        chk("seed busy", busy, 1);
        chk("seed out_valid", out_valid, 0);
        busy_cnt = 1;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
            if (busy) busy_cnt++;
        end
        chk("busy cycles", busy_cnt, INIT_ROUNDS);
        chk("first word latency", n, INIT_ROUNDS + K);
        chk("first word", out_data, exp_q[0]);
        for (int j = 1; j < 9; j++)
            for (int t = 1; t <= K; t++) begin
                tick();
                if (t < K) chk("gap out_valid", out_valid, 0);
                else begin
                    chk("rate out_valid", out_valid, 1);
                    chk("rate word", out_data, exp_q[j]);
                end
            end

        // all-zero seed must not lock up
        model(32'h0, 1000);
        do_seed(32'h0);
        collect(1000, 1'b1, "seed0", varied);
        chk("seed0 varied", varied, 1);

        // back-pressure on the first word, then no bits lost
        sd = $urandom;
        model(sd, 3);
        out_ready = 1'b0;
        do_seed(sd);
        wait_valid(n);
        chk("bp latency", n, INIT_ROUNDS + K);
        chk("bp word0", out_data, exp_q[0]);
        repeat (20) begin
            tick();
            chk("bp valid held", out_valid, 1);
            chk("bp data held", out_data, exp_q[0]);
        end
        out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        collect(2, 1'b0, "bp next", varied);

        // reseed while a word is pending, with a simultaneous handshake
        sd = $urandom;
        model(sd, 1);
        out_ready = 1'b0;
        do_seed(sd);
        wait_valid(n);
        chk("reseed pending", out_valid, 1);
        sd = $urandom;
        model(sd, 6);
        out_ready = 1'b1;
        do_seed(sd);
        chk("reseed drops word", out_valid, 0);
        chk("reseed busy", busy, 1);
        wait_valid(n);
        chk("reseed latency", n, INIT_ROUNDS + K);
        collect(6, 1'b1, "reseed", varied);

        // reset in INIT, no seed afterwards
        do_seed($urandom);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        tick();
        rst = 1'b1;
        bad = 0;
        repeat (200) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (out_valid || busy || out_data != '0 || health_fail) bad++;
        end
        chk("idle after reset", bad, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
